// File: rtl/pixel_tx_pkg.sv
// Shared definitions for the pixel serializer transmit path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pixel_tx_pkg;

  localparam int PIXEL_W = 24;
  localparam logic [PIXEL_W-1:0] IDLE_PIXEL_DEFAULT = 24'h000000;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO: storage, rd/wr pointers, occupancy count, full/empty flags.
// Latency: a word written at edge t is visible on rd_data from edge t onward once it is the head.
// Backpressure: writes are dropped when full, reads are ignored when empty; head is combinational.
// Ports: clk/rst_n; wr_en/wr_data push; rd_en pops the head shown on rd_data; full/empty status.
module pixel_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: a zero count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/pixel_serializer.sv
// Serializes buffered RGB pixels MSB-first into back-to-back PIXEL_W-bit slots, inserting IDLE_PIXEL on underrun.
// Latency: pixel accepted at edge t in IDLE with tx_en from t+1 shows its MSB in the cycle after t+1.
// Backpressure: pix_ready drops while the FIFO is full; the serial side never stalls.
// Ports: clk/rst_n; tx_en gates slot generation; pix_data/pix_valid/pix_ready input handshake;
//        serial_data bit stream; slot_start/pix_sent/idle_slot one-cycle strobes aligned with bit 0.
module pixel_serializer #(
  parameter int                      PIXEL_W    = pixel_tx_pkg::PIXEL_W,
  parameter int                      FIFO_DEPTH = 4,
  parameter logic [PIXEL_W-1:0]      IDLE_PIXEL = pixel_tx_pkg::IDLE_PIXEL_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tx_en,
  input  logic [PIXEL_W-1:0] pix_data,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic               serial_data,
  output logic               slot_start,
  output logic               pix_sent,
  output logic               idle_slot
);

  import pixel_tx_pkg::*;

  localparam int                CNT_W = $clog2(PIXEL_W);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(PIXEL_W - 1);

  tx_state_t          state_q;
  tx_state_t          state_d;
  logic [CNT_W-1:0]   bit_cnt;
  logic [PIXEL_W-1:0] shift_q;
  logic               slot_end;
  logic               slot_load;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [PIXEL_W-1:0] fifo_head;
  logic [PIXEL_W-1:0] load_pix;

  pixel_fifo #(
    .W     (PIXEL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pix_valid && pix_ready),
    .wr_data (pix_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign pix_ready = !fifo_full;
  assign slot_end  = (state_q == TX_SEND) && (bit_cnt == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= TX_IDLE;
    else        state_q <= state_d;
  end

  // Next state: leaving SEND only happens on a slot boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE: if (tx_en) state_d = TX_SEND;
      TX_SEND: if (slot_end && !tx_en) state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase
  end

  // Slot load decision; uses FIFO state before any same-edge write (no bypass).
  always_comb begin
    slot_load = 1'b0;
    case (state_q)
      TX_IDLE: slot_load = tx_en;
      TX_SEND: slot_load = slot_end && tx_en;
      default: slot_load = 1'b0;
    endcase
  end

  assign pop      = slot_load && !fifo_empty;
  assign load_pix = fifo_empty ? IDLE_PIXEL : fifo_head;

  // Datapath: the MSB is registered straight to serial_data on the load edge,
  // the shift register holds the remaining bits left-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      shift_q     <= '0;
      serial_data <= 1'b0;
      slot_start  <= 1'b0;
      pix_sent    <= 1'b0;
      idle_slot   <= 1'b0;
    end else begin
      slot_start <= slot_load;
      pix_sent   <= pop;
      idle_slot  <= slot_load && fifo_empty;
      if (slot_load) begin
        bit_cnt     <= '0;
        serial_data <= load_pix[PIXEL_W-1];
        shift_q     <= {load_pix[PIXEL_W-2:0], 1'b0};
      end else if (state_q == TX_SEND && !slot_end) begin
        bit_cnt     <= bit_cnt + 1'b1;
        serial_data <= shift_q[PIXEL_W-1];
        shift_q     <= {shift_q[PIXEL_W-2:0], 1'b0};
      end else begin
        bit_cnt     <= '0;
        serial_data <= 1'b0;
        shift_q     <= '0;
      end
    end
  end

endmodule
